// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration limits for the pipelined add/subtract unit.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Control word of one pipeline stage; the WIDTH-sized operand and
  // partial-sum vectors travel beside it because their size is a module parameter.
  typedef struct packed {
    logic valid;
    logic carry;
    op_e  op;
  } stage_t;

  function automatic logic stages_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; ovf exists only with PIPE_ADDER_OVF_EN.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipe_adder_seg.sv
// One carry segment of pipe_adder: adds segment IDX of the operands with the
// incoming carry and registers the result together with the forwarded operands.
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 16,
  parameter int IDX   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  stage_t           d_ctl,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic [WIDTH-1:0] d_sum,
  output stage_t           q_ctl,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_sum
);

  logic [SEG:0]     seg_res;
  logic [WIDTH-1:0] sum_nxt;

  assign seg_res = {1'b0, d_a[IDX*SEG +: SEG]} + {1'b0, d_b[IDX*SEG +: SEG]}
                 + {{SEG{1'b0}}, d_ctl.carry};

  // Segments at and above IDX are still zero in d_sum, so OR-ing places this slice.
  assign sum_nxt = d_sum | (WIDTH'(seg_res[SEG-1:0]) << (IDX * SEG));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_ctl <= '0;
      q_a   <= '0;
      q_b   <= '0;
      q_sum <= '0;
    end else if (en) begin
      q_ctl.valid <= d_ctl.valid;
      q_ctl.carry <= seg_res[SEG];
      q_ctl.op    <= d_ctl.op;
      q_a         <= d_a;
      q_b         <= d_b;
      q_sum       <= sum_nxt;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: STAGES carry segments, one register each, single global
// advance enable. Define PIPE_ADDER_OVF_EN to add the signed-overflow output.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  pipe_adder_if.slave  bus
);

  localparam int SEG = WIDTH / ((STAGES > 0) ? STAGES : 1);

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $fatal(1, "pipe_adder: WIDTH=%0d must divide by STAGES=%0d, STAGES in 1..%0d",
           WIDTH, STAGES, MAX_STAGES);
  end

  // Index 0 is the combinational input side; index k+1 is the register of stage k.
  stage_t [STAGES:0]            ctl;
  logic   [STAGES:0][WIDTH-1:0] opa;
  logic   [STAGES:0][WIDTH-1:0] opb;
  logic   [STAGES:0][WIDTH-1:0] psum;
  logic                         adv;

  // Whole pipe moves or whole pipe holds; bubbles are kept.
  assign adv          = bus.out_ready | ~ctl[STAGES].valid;
  assign bus.in_ready = adv;

  // SUB is a + ~b + 1: invert b once here and seed the chain with 1.
  assign ctl[0].valid = bus.in_valid;
  assign ctl[0].carry = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
  assign ctl[0].op    = bus.op;
  assign opa[0]       = bus.a;
  assign opb[0]       = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  assign psum[0]      = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_seg #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .IDX   (k)
    ) u_seg (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .d_ctl (ctl[k]),
      .d_a   (opa[k]),
      .d_b   (opb[k]),
      .d_sum (psum[k]),
      .q_ctl (ctl[k+1]),
      .q_a   (opa[k+1]),
      .q_b   (opb[k+1]),
      .q_sum (psum[k+1])
    );
  end

  assign bus.out_valid = ctl[STAGES].valid;
  assign bus.sum       = psum[STAGES];
  assign bus.cout      = ctl[STAGES].carry;

`ifdef PIPE_ADDER_OVF_EN
  // b is already inverted for SUB, so one rule covers both ops. Driven purely from
  // last-stage registers: it holds and resets exactly like sum.
  assign bus.ovf = (opa[STAGES][WIDTH-1] == opb[STAGES][WIDTH-1])
                 & (psum[STAGES][WIDTH-1] != opa[STAGES][WIDTH-1]);
`endif

  logic unused;
  assign unused = ^{opa[STAGES], opb[STAGES], ctl[STAGES].op};

endmodule
